aes_build_core: RTL and testbench
=================================

# aes_build_core

Iterative AES round engine that encrypts one 128-bit block with externally expanded round keys, then immediately decrypts the ciphertext with the same keys, returning the recovered plaintext as a self-check. The block sits downstream of the key-expansion logic: it consumes that logic's `ready` flag and round-key array. Both the ciphertext and the round-trip plaintext are exported. Sequential state is built from the codebase register cells (`rregs`-style flops), extended with the asynchronous clear below.

## Interface
Parameters: none. Widths are fixed by the AES standard.

Ports:
- `eph1`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; state clears while `reset`=0.
- `ready`  in  1  key-expansion-valid flag; its rising edge starts one operation.
- `plain_text`  in  128  input block; bits [127:120] are AES byte 0.
- `key_size`  in  2  key length: 00 = AES-128 (Nr=10), 01 = AES-192 (Nr=12), 10/11 = AES-256 (Nr=14).
- `key_words`  in  15×128 (`[15:1][127:0]`)  round keys; index 15 = round-0 key, index 15−r = round-r key; unused low indices are ignored.
- `aes_encrypted`  out  128  ciphertext.
- `aes_encrypt_done`  out  1  ciphertext valid (sticky).
- `aes_decrypted`  out  128  decrypted ciphertext; equals `plain_text` when keys are consistent.
- `aes_decrypt_done`  out  1  round trip complete (sticky).

## Operation
- FSM states: IDLE, ENC, DEC, DONE.
- Start condition: `start = ready & ~ready_q`, where `ready_q` is `ready` delayed one cycle and cleared by reset.
  - `ready` already high at the first edge after reset release counts as a start.
  - A level held high afterwards does not restart the block.
- Start is honoured in IDLE and DONE. It is ignored in ENC and DEC.
- On start:
  - latch `plain_text` and `key_size`;
  - state ← plain_text ^ key_words[15];
  - round counter r ← 1;
  - both done flags ← 0;
  - move to ENC.
- `key_words` is not latched. It must stay stable from start until `aes_decrypt_done`.
- ENC, rounds r = 1..Nr−1: SubBytes, ShiftRows, MixColumns, then AddRoundKey(key_words[15−r]).
- ENC, round Nr: same as above but without MixColumns. At this round:
  - write the result to `aes_encrypted` and set `aes_encrypt_done`;
  - load state ← result ^ key_words[15−Nr];
  - set i ← Nr−1 and move to DEC.
- DEC, each cycle: InvShiftRows, InvSubBytes, AddRoundKey(key_words[15−i]), then InvMixColumns only when i ≥ 1; then i decrements.
- DEC, after i = 0: write the result to `aes_decrypted`, set `aes_decrypt_done`, move to DONE.
- S-box and inverse S-box are computed as GF(2^8) inverse (polynomial 0x11B) plus the affine transform, or its inverse. 0x00 maps to 0x63.
- MixColumns uses the standard {02,03,01,01} matrix; InvMixColumns uses {0e,0b,0d,09}.
- Byte order: column c = bytes 4c..4c+3; ShiftRows rotates row k left by k.

## Timing
- Reset (`reset`=0, asynchronous):
  - FSM → IDLE; `ready_q`, counters and internal state → 0;
  - all outputs → 0: `aes_encrypted`, `aes_decrypted`, `aes_encrypt_done`, `aes_decrypt_done`.
- Let edge 0 be the edge that samples start.
  - The whitening XOR completes at edge 0.
  - `aes_encrypt_done` rises after edge Nr: 10 / 12 / 14.
  - `aes_decrypt_done` rises after edge 2·Nr: 20 / 24 / 28.
- Outputs are registered and stay valid until the next accepted start or reset.
- The next accepted start clears both done flags at its edge 0.
- `aes_encrypted` keeps its old value until overwritten at edge Nr of the next operation.
- Reset asserted mid-operation aborts the operation. Nothing completes. A fresh `ready` rising edge is required afterwards.
- A `ready` rising edge during ENC/DEC is lost. It is not queued.

## Test plan
Round keys come from a bench-side FIPS-197 key expansion, loaded at indices 15 downward.

- AES-128, key 000102…0f, pt 00112233445566778899aabbccddeeff → `aes_encrypted` = 69c4e0d86a7b0430d8cdb78070b4c55a at edge 10; `aes_decrypted` = pt at edge 20.
- AES-192, key 000102…17, same pt → ct dda97ca4864cdfe06eaf70a0ec0d7191 at edge 12; pt recovered at edge 24.
- AES-256 (`key_size`=10 and again with 11), key 000102…1f, same pt → ct 8ea2b7ca516745bfeafc49904b496089 at edge 14; pt recovered at edge 28.
- `ready` held high after reset release → exactly one operation; after DONE, `aes_decrypt_done` stays 1 and no restart occurs. Toggle `ready` low→high → new run, done flags cleared at edge 0.
- Pull `reset` low at edge 5 of an AES-256 run → all outputs 0 immediately; no done flag appears until a new `ready` rising edge.
- Extra `ready` rising edge at edge 3 of a run → ignored; the original completion cycles and values are unchanged.

Source files
------------

// File: rtl/aes_build_core.sv
// aes_build_core: iterative AES engine. Encrypts one 128-bit block with
// externally expanded round keys (one round per clock), then decrypts the
// ciphertext with the same keys so the round trip can be checked.
// Ports:
//   eph1             clock, all state updates on its rising edge
//   reset            asynchronous active-low reset
//   ready            key-expansion-valid; its rising edge starts one operation
//   plain_text       input block, bits [127:120] are AES byte 0
//   key_size         00 AES-128, 01 AES-192, 1x AES-256
//   key_words        round keys, index 15-r holds the round-r key
//   aes_encrypted    ciphertext (registered)
//   aes_encrypt_done ciphertext valid, sticky until the next start
//   aes_decrypted    recovered plaintext (registered)
//   aes_decrypt_done round trip complete, sticky until the next start
module aes_build_core (
    input  logic               eph1,
    input  logic               reset,
    input  logic               ready,
    input  logic [127:0]       plain_text,
    input  logic [1:0]         key_size,
    input  logic [15:1][127:0] key_words,
    output logic [127:0]       aes_encrypted,
    output logic               aes_encrypt_done,
    output logic [127:0]       aes_decrypted,
    output logic               aes_decrypt_done
);

    localparam int unsigned BLK_W = 128;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_ENC, ST_DEC, ST_DONE} state_t;

    // GF(2^8) helpers, reduction polynomial 0x11B
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // x^254 via square-and-multiply; maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gmul(a, a);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            if (!inv) begin
                o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end else begin
                o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
                o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
                o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
                o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
            end
        end
        return o;
    endfunction

    state_t           r_fsm;
    logic             r_ready_q;
    logic [BLK_W-1:0] r_state;
    logic [CNT_W-1:0] r_rnd;
    logic [1:0]       r_key_size;

    logic             w_start;
    logic             w_dec;
    logic [CNT_W-1:0] w_nr;
    logic [BLK_W-1:0] w_rkey;
    logic [BLK_W-1:0] w_last_key;
    logic [BLK_W-1:0] w_sub;
    logic [BLK_W-1:0] w_shift;
    logic [BLK_W-1:0] w_enc_out;
    logic [BLK_W-1:0] w_dec_add;
    logic [BLK_W-1:0] w_dec_out;

    assign w_start    = ready & ~r_ready_q;
    assign w_dec      = (r_fsm == ST_DEC);
    assign w_nr       = (r_key_size == 2'b00) ? CNT_W'(10) :
                        (r_key_size == 2'b01) ? CNT_W'(12) : CNT_W'(14);
    // Encrypt round r and decrypt step i both use key index 15 - counter
    assign w_rkey     = key_words[CNT_W'(15) - r_rnd];
    assign w_last_key = key_words[CNT_W'(15) - w_nr];

    // One shared GF inverse per byte: forward S-box in ENC, inverse in DEC.
    // SubBytes and ShiftRows commute, so substitution is done first.
    always_comb begin
        w_sub   = '0;
        w_shift = '0;
        for (int b = 0; b < 16; b++) begin
            w_sub[127-8*b -: 8] = w_dec ? ginv(inv_affine(r_state[127-8*b -: 8]))
                                        : affine(ginv(r_state[127-8*b -: 8]));
        end
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                w_shift[127-8*(4*c+k) -: 8] = w_dec ? w_sub[127-8*(4*((c+4-k)%4)+k) -: 8]
                                                    : w_sub[127-8*(4*((c+k)%4)+k) -: 8];
            end
        end
    end

    assign w_enc_out = ((r_rnd == w_nr) ? w_shift : mix_cols(w_shift, 1'b0)) ^ w_rkey;
    assign w_dec_add = w_shift ^ w_rkey;
    assign w_dec_out = (r_rnd != '0) ? mix_cols(w_dec_add, 1'b1) : w_dec_add;

    // Control FSM with registered outputs
    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset) begin
            r_fsm            <= ST_IDLE;
            r_ready_q        <= 1'b0;
            r_state          <= '0;
            r_rnd            <= '0;
            r_key_size       <= '0;
            aes_encrypted    <= '0;
            aes_encrypt_done <= 1'b0;
            aes_decrypted    <= '0;
            aes_decrypt_done <= 1'b0;
        end else begin
            r_ready_q <= ready;
            case (r_fsm)
                ST_IDLE, ST_DONE: begin
                    if (w_start) begin
                        r_state          <= plain_text ^ key_words[15];
                        r_key_size       <= key_size;
                        r_rnd            <= CNT_W'(1);
                        aes_encrypt_done <= 1'b0;
                        aes_decrypt_done <= 1'b0;
                        r_fsm            <= ST_ENC;
                    end
                end
                ST_ENC: begin
                    if (r_rnd == w_nr) begin
                        aes_encrypted    <= w_enc_out;
                        aes_encrypt_done <= 1'b1;
                        // Decryption starts from ciphertext ^ last round key
                        r_state          <= w_enc_out ^ w_last_key;
                        r_rnd            <= w_nr - CNT_W'(1);
                        r_fsm            <= ST_DEC;
                    end else begin
                        r_state <= w_enc_out;
                        r_rnd   <= r_rnd + CNT_W'(1);
                    end
                end
                ST_DEC: begin
                    if (r_rnd == '0) begin
                        aes_decrypted    <= w_dec_out;
                        aes_decrypt_done <= 1'b1;
                        r_fsm            <= ST_DONE;
                    end else begin
                        r_state <= w_dec_out;
                        r_rnd   <= r_rnd - CNT_W'(1);
                    end
                end
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_build_core.sv
// Bench for aes_build_core: FIPS-197 vectors with bench-side key expansion,
// scoreboard of expected ciphertext/plaintext, reset and ready-edge cases.
module tb_aes_build_core;

    logic               eph1;
    logic               reset;
    logic               ready;
    logic [127:0]       plain_text;
    logic [1:0]         key_size;
    logic [15:1][127:0] key_words;
    logic [127:0]       aes_encrypted;
    logic               aes_encrypt_done;
    logic [127:0]       aes_decrypted;
    logic               aes_decrypt_done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] ct;
    } exp_t;
    exp_t sb_q[$];

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    aes_build_core dut (
        .eph1             (eph1),
        .reset            (reset),
        .ready            (ready),
        .plain_text       (plain_text),
        .key_size         (key_size),
        .key_words        (key_words),
        .aes_encrypted    (aes_encrypted),
        .aes_encrypt_done (aes_encrypt_done),
        .aes_decrypted    (aes_decrypted),
        .aes_decrypt_done (aes_decrypt_done)
    );

    initial eph1 = 1'b0;
    always #5 eph1 = ~eph1;

    function automatic logic [7:0] tb_xtime(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = tb_xtime(x);
        end
        return p;
    endfunction

    // S-box by brute-force inverse search and bitwise affine map
    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        inv = 8'h00;
        c   = 8'h63;
        for (int y = 1; y < 256; y++)
            if (tb_gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
        return s;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
    endfunction

    task automatic load_keys(input logic [255:0] key, input logic [1:0] ks);
        logic [31:0] w [60];
        logic [31:0] temp;
        logic [7:0]  rcon;
        int nk;
        int nr;
        nk   = (ks == 2'b00) ? 4 : (ks == 2'b01) ? 6 : 8;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
                rcon = tb_xtime(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                temp = sub_word(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        @(negedge eph1);
        for (int i = 1; i <= 15; i++)
            key_words[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int r = 0; r <= nr; r++)
            key_words[15-r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Raise ready at a falling edge; returns just after edge 0
    task automatic launch(input logic [1:0] ks, input logic [127:0] pt, input logic [127:0] ct);
        exp_t ex;
        @(negedge eph1);
        plain_text = pt;
        key_size   = ks;
        ready      = 1'b1;
        ex.pt = pt;
        ex.ct = ct;
        sb_q.push_back(ex);
        @(posedge eph1);
    endtask

    // Called just after edge 0: checks done timing and scoreboard results
    task automatic follow(input int nr, input bit hold, input int glitch_at);
        exp_t ex;
        #1;
        checks++;
        if (aes_encrypt_done !== 1'b0 || aes_decrypt_done !== 1'b0) begin
            failures++;
            $display("FAIL start_clear: enc_done=%b dec_done=%b, required 0 0", aes_encrypt_done, aes_decrypt_done);
        end
        for (int e = 1; e <= 2*nr; e++) begin
            @(posedge eph1);
            #1;
            if (!hold && e == 1) ready = 1'b0;
            if (glitch_at > 0 && e == glitch_at - 1) ready = 1'b1;
            if (glitch_at > 0 && e == glitch_at + 1) ready = 1'b0;
            if (e == nr - 1) begin
                checks++;
                if (aes_encrypt_done !== 1'b0) begin
                    failures++;
                    $display("FAIL enc_done_early nr=%0d: got %b at edge %0d, required 0", nr, aes_encrypt_done, e);
                end
            end
            if (e == nr) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_empty nr=%0d at edge %0d", nr, e);
                end else if (aes_encrypt_done !== 1'b1 || aes_encrypted !== sb_q[0].ct) begin
                    failures++;
                    $display("FAIL ciphertext nr=%0d: done=%b ct=%h, required done=1 ct=%h", nr, aes_encrypt_done, aes_encrypted, sb_q[0].ct);
                end
            end
            if (e == 2*nr - 1) begin
                checks++;
                if (aes_decrypt_done !== 1'b0) begin
                    failures++;
                    $display("FAIL dec_done_early nr=%0d: got %b at edge %0d, required 0", nr, aes_decrypt_done, e);
                end
            end
            if (e == 2*nr) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_empty nr=%0d at edge %0d", nr, e);
                end else begin
                    ex = sb_q.pop_front();
                    if (aes_decrypt_done !== 1'b1 || aes_decrypted !== ex.pt || aes_encrypted !== ex.ct) begin
                        failures++;
                        $display("FAIL round_trip nr=%0d: done=%b pt=%h ct=%h, required done=1 pt=%h ct=%h",
                                 nr, aes_decrypt_done, aes_decrypted, aes_encrypted, ex.pt, ex.ct);
                    end
                end
            end
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (aes_encrypted !== '0 || aes_decrypted !== '0 || aes_encrypt_done !== 1'b0 || aes_decrypt_done !== 1'b0) begin
            failures++;
            $display("FAIL %s: ct=%h pt=%h enc_done=%b dec_done=%b, required all 0",
                     name, aes_encrypted, aes_decrypted, aes_encrypt_done, aes_decrypt_done);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (3) @(posedge eph1);
        #1;
        check_zero("reset_state");
        @(negedge eph1);
        reset = 1'b1;
        repeat (3) @(posedge eph1);
        #1;
        check_zero("idle_no_start");
    endtask

    task automatic test_aes128();
        load_keys(KEY128, 2'b00);
        launch(2'b00, PT, CT128);
        follow(10, 1'b0, 0);
    endtask

    task automatic test_aes192();
        load_keys(KEY192, 2'b01);
        launch(2'b01, PT, CT192);
        follow(12, 1'b0, 0);
    endtask

    task automatic test_aes256();
        load_keys(KEY256, 2'b10);
        launch(2'b10, PT, CT256);
        follow(14, 1'b0, 0);
        launch(2'b11, PT, CT256);
        follow(14, 1'b0, 0);
    endtask

    task automatic test_ready_held();
        exp_t ex;
        @(negedge eph1);
        reset = 1'b0;
        load_keys(KEY128, 2'b00);
        plain_text = PT;
        key_size   = 2'b00;
        ready      = 1'b1;
        ex.pt = PT;
        ex.ct = CT128;
        sb_q.push_back(ex);
        repeat (2) @(posedge eph1);
        @(negedge eph1);
        reset = 1'b1;
        @(posedge eph1);
        follow(10, 1'b1, 0);
        repeat (20) @(posedge eph1);
        #1;
        checks++;
        if (aes_encrypt_done !== 1'b1 || aes_decrypt_done !== 1'b1 || aes_decrypted !== PT) begin
            failures++;
            $display("FAIL held_no_restart: enc_done=%b dec_done=%b pt=%h, required 1 1 %h",
                     aes_encrypt_done, aes_decrypt_done, aes_decrypted, PT);
        end
        @(negedge eph1);
        ready = 1'b0;
        launch(2'b00, PT, CT128);
        follow(10, 1'b0, 0);
    endtask

    task automatic test_reset_mid_run();
        load_keys(KEY256, 2'b10);
        launch(2'b10, PT, CT256);
        for (int e = 1; e <= 5; e++) begin
            @(posedge eph1);
            #1;
            if (e == 1) ready = 1'b0;
        end
        reset = 1'b0;
        #1;
        check_zero("reset_mid_run");
        void'(sb_q.pop_back());
        repeat (2) @(posedge eph1);
        @(negedge eph1);
        reset = 1'b1;
        repeat (40) @(posedge eph1);
        #1;
        check_zero("no_done_after_abort");
        launch(2'b10, PT, CT256);
        follow(14, 1'b0, 0);
    endtask

    task automatic test_extra_ready();
        load_keys(KEY192, 2'b01);
        launch(2'b01, PT, CT192);
        follow(12, 1'b0, 3);
        repeat (6) @(posedge eph1);
        #1;
        checks++;
        if (aes_encrypt_done !== 1'b1 || aes_decrypt_done !== 1'b1 || aes_encrypted !== CT192) begin
            failures++;
            $display("FAIL extra_ready_restart: enc_done=%b dec_done=%b ct=%h, required 1 1 %h",
                     aes_encrypt_done, aes_decrypt_done, aes_encrypted, CT192);
        end
    endtask

    initial begin
        reset      = 1'b1;
        ready      = 1'b0;
        plain_text = '0;
        key_size   = 2'b00;
        key_words  = '0;
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_ready_held();
        test_reset_mid_run();
        test_extra_ready();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: %0d entries, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
